// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer_if
//  Brief    : Sample-in / result-out handshakes and coefficient programming
//             port of the time-multiplexed FIR MAC sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_sequencer_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int COEFF_WIDTH    = 16,
    parameter int TAP_ADDR_WIDTH = 2,
    parameter int OUT_WIDTH      = 19
);
    logic signed [DATA_WIDTH-1:0]  i_data;
    logic                          i_data_valid;
    logic                          o_data_ready;
    logic signed [OUT_WIDTH-1:0]   o_data_sum;
    logic                          o_data_valid;
    logic                          i_data_ready;
    logic                          i_coeff_we;
    logic [TAP_ADDR_WIDTH-1:0]     i_coeff_addr;
    logic signed [COEFF_WIDTH-1:0] i_coeff_data;
    logic                          i_coeff_commit;
    logic                          o_commit_pending;
    logic                          o_busy;

    // Filter side
    modport slave (
        input  i_data, i_data_valid, i_data_ready,
        input  i_coeff_we, i_coeff_addr, i_coeff_data, i_coeff_commit,
        output o_data_ready, o_data_sum, o_data_valid,
        output o_commit_pending, o_busy
    );

    // Driver side
    modport master (
        output i_data, i_data_valid, i_data_ready,
        output i_coeff_we, i_coeff_addr, i_coeff_data, i_coeff_commit,
        input  o_data_ready, o_data_sum, o_data_valid,
        input  o_commit_pending, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer
//  Brief    : Direct-form FIR with one shared multiply-accumulate sequenced
//             over NUM_TAPS taps per sample, valid/ready sample and result
//             handshakes and a shadow/active double-buffered coefficient bank.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int DATA_WIDTH           = 16,
    parameter int COEFF_WIDTH          = 16,
    parameter int COEFF_FRACTION_WIDTH = 15,
    parameter int NUM_TAPS             = 4,
    parameter int TAP_ADDR_WIDTH       = $clog2(NUM_TAPS),
    parameter int OUT_WIDTH            = DATA_WIDTH + COEFF_WIDTH - COEFF_FRACTION_WIDTH + 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    fir_mac_sequencer_if.slave    bus
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [TAP_ADDR_WIDTH-1:0] c_ONE      = TAP_ADDR_WIDTH'(1);
    localparam logic [TAP_ADDR_WIDTH-1:0] c_LAST_TAP = TAP_ADDR_WIDTH'(NUM_TAPS - 1);
    // NUM_TAPS folded into the address width; zero when NUM_TAPS is a power of two
    localparam logic [TAP_ADDR_WIDTH-1:0] c_TAPS_MOD = TAP_ADDR_WIDTH'(NUM_TAPS);
    localparam logic [TAP_ADDR_WIDTH:0]   c_TAPS_EXT = (TAP_ADDR_WIDTH + 1)'(NUM_TAPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic signed [DATA_WIDTH-1:0]   r_hist [NUM_TAPS];
    logic [TAP_ADDR_WIDTH-1:0]      r_wr_ptr;
    logic [TAP_ADDR_WIDTH-1:0]      r_tap_idx;
    logic signed [OUT_WIDTH-1:0]    r_acc;
    logic signed [OUT_WIDTH-1:0]    r_sum;
    logic signed [COEFF_WIDTH-1:0]  r_shadow [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0]  r_active [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0]  w_shadow_next [NUM_TAPS];
    logic                           r_pending;

    logic [TAP_ADDR_WIDTH-1:0]      w_rd_idx;
    logic [TAP_ADDR_WIDTH-1:0]      w_wr_ptr_next;
    logic                           w_last_tap;
    logic                           w_addr_ok;
    logic                           w_apply;
    logic signed [PROD_WIDTH-1:0]   w_tap_data;
    logic signed [PROD_WIDTH-1:0]   w_tap_coeff;
    logic signed [PROD_WIDTH-1:0]   w_prod;
    logic signed [OUT_WIDTH-1:0]    w_acc_next;

    // Tap k reads x(n-k): walk backwards from the newest slot, wrapping mod NUM_TAPS
    assign w_rd_idx = (r_wr_ptr >= r_tap_idx) ? (r_wr_ptr - r_tap_idx)
                                              : (r_wr_ptr - r_tap_idx + c_TAPS_MOD);
    assign w_wr_ptr_next = (r_wr_ptr == c_LAST_TAP) ? '0 : (r_wr_ptr + c_ONE);
    assign w_last_tap    = (r_tap_idx == c_LAST_TAP);
    assign w_addr_ok     = ({1'b0, bus.i_coeff_addr} < c_TAPS_EXT);
    // A pending or fresh commit lands on any edge seen in IDLE
    assign w_apply       = (r_state == S_IDLE) && (r_pending || bus.i_coeff_commit);

    // Full-precision product, floor-shifted per tap, then wrapped into the accumulator
    assign w_tap_data  = PROD_WIDTH'(r_hist[w_rd_idx]);
    assign w_tap_coeff = PROD_WIDTH'(r_active[r_tap_idx]);
    assign w_prod      = w_tap_data * w_tap_coeff;
    assign w_acc_next  = r_acc + OUT_WIDTH'(w_prod >>> COEFF_FRACTION_WIDTH);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept -> NUM_TAPS MAC cycles -> hold result until taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_data_valid) w_state_next = S_MAC;
            S_MAC:   if (w_last_tap)       w_state_next = S_OUT;
            S_OUT:   if (bus.i_data_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sample history, tap sequencing, accumulation and result register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_hist[k] <= '0;
            end
            r_wr_ptr  <= '0;
            r_tap_idx <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_data_valid) begin
                        r_hist[r_wr_ptr] <= bus.i_data;
                        r_acc            <= '0;
                        r_tap_idx        <= '0;
                    end
                end
                S_MAC: begin
                    r_acc     <= w_acc_next;
                    r_tap_idx <= r_tap_idx + c_ONE;
                    if (w_last_tap) begin
                        r_sum    <= w_acc_next;
                        r_wr_ptr <= w_wr_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shadow bank with this cycle's write folded in, so a same-edge commit sees it
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_shadow_next[k] = r_shadow[k];
            if (bus.i_coeff_we && w_addr_ok && (bus.i_coeff_addr == TAP_ADDR_WIDTH'(k))) begin
                w_shadow_next[k] = bus.i_coeff_data;
            end
        end
    end

    // Coefficient banks and commit tracking; active bank only changes in IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_pending <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_shadow[k] <= w_shadow_next[k];
            end
            if (w_apply) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    r_active[k] <= w_shadow_next[k];
                end
                r_pending <= 1'b0;
            end else if (bus.i_coeff_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.o_data_ready     = (r_state == S_IDLE) && reset_n;
    assign bus.o_data_valid     = (r_state == S_OUT);
    assign bus.o_data_sum       = r_sum;
    assign bus.o_commit_pending = r_pending;
    assign bus.o_busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fir_mac_sequencer
//  Brief    : Self-checking bench for fir_mac_sequencer with a tap-sum
//             reference model (history list x(n-k) times active h[k]).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int FW = 15;
    localparam int NT = 4;
    localparam int AW = $clog2(NT);
    localparam int OW = DW + CW - FW + 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW),
                           .TAP_ADDR_WIDTH(AW), .OUT_WIDTH(OW)) bus ();

    fir_mac_sequencer #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .COEFF_FRACTION_WIDTH(FW),
                        .NUM_TAPS(NT), .TAP_ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int m_hist   [NT];   // m_hist[k] = x(n-k)
    int m_shadow [NT];
    int m_active [NT];
    bit m_pending;

    function automatic int sxd(input int v);
        logic signed [DW-1:0] t;
        t = DW'(v);
        return int'(t);
    endfunction

    function automatic int sxc(input int v);
        logic signed [CW-1:0] t;
        t = CW'(v);
        return int'(t);
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < NT; k++) begin
            m_hist[k] = 0; m_shadow[k] = 0; m_active[k] = 0;
        end
        m_pending = 1'b0;
    endfunction

    function automatic void m_commit(input bit idle);
        if (idle) begin
            for (int k = 0; k < NT; k++) m_active[k] = m_shadow[k];
            m_pending = 1'b0;
        end else begin
            m_pending = 1'b1;
        end
    endfunction

    function automatic logic [OW-1:0] m_push(input int x);
        longint acc;
        logic [63:0] a;
        if (m_pending) m_commit(1'b1);
        for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = sxd(x);
        acc = 0;
        for (int k = 0; k < NT; k++) acc += (longint'(m_hist[k]) * longint'(m_active[k])) >>> FW;
        a = acc;
        return a[OW-1:0];
    endfunction

    function automatic int rnd16();
        return sxd(int'($urandom));
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.i_data_valid = 1'b0; bus.i_data_ready = 1'b1;
        bus.i_coeff_we = 1'b0; bus.i_coeff_commit = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        m_reset();
        #1;
    endtask

    // Writes h[0..NT-1]; the commit shares the edge with the last write
    task automatic load_coeffs(input int h[NT]);
        for (int k = 0; k < NT; k++) begin
            bus.i_coeff_we     = 1'b1;
            bus.i_coeff_addr   = AW'(k);
            bus.i_coeff_data   = CW'(h[k]);
            bus.i_coeff_commit = (k == NT - 1);
            m_shadow[k] = sxc(h[k]);
            tick();
        end
        m_commit(1'b1);
        bus.i_coeff_we = 1'b0; bus.i_coeff_commit = 1'b0;
    endtask

    // Offers x, counts edges from accept to valid, handshakes if i_data_ready
    task automatic run_sample(input int x, output logic [OW-1:0] sum,
                              output int lat, output bit busy_ok);
        bus.i_data = DW'(x); bus.i_data_valid = 1'b1;
        lat = 0;
        while (!bus.o_data_ready && lat < 50) begin tick(); lat++; end
        tick();
        bus.i_data_valid = 1'b0;
        busy_ok = 1'b1; lat = 0;
        while (!bus.o_data_valid && lat < 50) begin
            if (!bus.o_busy) busy_ok = 1'b0;
            tick(); lat++;
        end
        if (!bus.o_busy) busy_ok = 1'b0;
        sum = bus.o_data_sum;
        if (bus.i_data_ready) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        bus.i_data = '0; bus.i_data_valid = 1'b1; bus.i_data_ready = 1'b1;
        bus.i_coeff_we = 1'b0; bus.i_coeff_addr = '0; bus.i_coeff_data = '0; bus.i_coeff_commit = 1'b0;
        tick(); tick();
        n_tests++;
        if (bus.o_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", bus.o_data_ready); end
        n_tests++;
        if ({bus.o_busy, bus.o_data_valid, bus.o_commit_pending} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: busy/valid/pending got %b%b%b want 000", bus.o_busy, bus.o_data_valid, bus.o_commit_pending);
        end
        n_tests++;
        if (bus.o_data_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", bus.o_data_sum); end
        bus.i_data_valid = 1'b0;
        reset_n = 1'b1; m_reset(); #1;
        n_tests++;
        if (bus.o_data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %b want 1", bus.o_data_ready); end
    endtask

    task automatic test_impulse();
        int h[NT]; logic [OW-1:0] want[5]; logic [OW-1:0] got; int lat; bit bok;
        do_reset();
        h = '{32'h1000, 32'h2000, 32'h2000, 32'h1000};
        load_coeffs(h);
        want = '{19'h00800, 19'h01000, 19'h01000, 19'h00800, 19'h00000};
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 32'h4000 : 0, got, lat, bok);
            n_tests++;
            if (got !== want[i]) begin n_fail++; $display("FAIL impulse_sum[%0d]: got %h want %h", i, got, want[i]); end
            n_tests++;
            if (lat != NT) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, lat, NT); end
            n_tests++;
            if (!bok || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL impulse_busy[%0d]: during=%b after=%b want 1/0", i, bok, bus.o_busy); end
        end
    endtask

    task automatic test_step();
        int h[NT]; logic [OW-1:0] want[4]; logic [OW-1:0] got; int lat; bit bok;
        do_reset();
        for (int k = 0; k < NT; k++) h[k] = 32'h7FFF;
        load_coeffs(h);
        want = '{19'h07FFE, 19'h0FFFC, 19'h17FFA, 19'h1FFF8};
        for (int i = 0; i < 4; i++) begin
            run_sample(32'h7FFF, got, lat, bok);
            n_tests++;
            if (got !== want[i]) begin n_fail++; $display("FAIL step_sum[%0d]: got %h want %h", i, got, want[i]); end
        end
    endtask

    task automatic test_negative();
        int h[NT]; logic [OW-1:0] got, want; int lat; bit bok;
        do_reset();
        for (int k = 0; k < NT; k++) h[k] = 32'h1000;
        load_coeffs(h);
        for (int i = 0; i < 4; i++) begin
            want = OW'(-(i + 1));
            void'(m_push(sxd(32'hFFFF)));
            run_sample(32'hFFFF, got, lat, bok);
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL neg_sum[%0d]: got %h want %h", i, got, want); end
        end
        for (int i = 0; i < 4; i++) begin
            want = m_push(sxd(32'h8000));
            run_sample(32'h8000, got, lat, bok);
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL floor_sum[%0d]: got %h want %h", i, got, want); end
        end
        n_tests++;
        if (got !== 19'h7C000) begin n_fail++; $display("FAIL floor_final: got %h want 7c000", got); end
    endtask

    task automatic test_backpressure();
        int h[NT]; logic [OW-1:0] got, want; int lat, x; bit bok;
        do_reset();
        for (int k = 0; k < NT; k++) h[k] = rnd16();
        load_coeffs(h);
        for (int i = 0; i < 3; i++) begin
            x = rnd16(); want = m_push(x);
            run_sample(x, got, lat, bok);
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL bp_warmup[%0d]: got %h want %h", i, got, want); end
        end
        x = rnd16(); want = m_push(x);
        bus.i_data_ready = 1'b0;
        run_sample(x, got, lat, bok);
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL bp_result: got %h want %h", got, want); end
        for (int c = 0; c < 5; c++) begin
            bus.i_data_valid = 1'b1; bus.i_data = DW'(rnd16());
            tick();
            n_tests++;
            if (bus.o_data_valid !== 1'b1 || bus.o_data_sum !== want || bus.o_data_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: valid=%b sum=%h ready=%b want 1 %h 0", c, bus.o_data_valid, bus.o_data_sum, bus.o_data_ready, want);
            end
        end
        bus.i_data_valid = 1'b0; bus.i_data_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.o_busy !== 1'b0 || bus.o_data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: busy=%b valid=%b want 0 0", bus.o_busy, bus.o_data_valid); end
        x = rnd16(); want = m_push(x);
        run_sample(x, got, lat, bok);
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL bp_history: got %h want %h", got, want); end
    endtask

    task automatic test_commit_busy();
        int h[NT], hn[NT]; logic [OW-1:0] got, want; int lat, x; bit bok;
        do_reset();
        for (int k = 0; k < NT; k++) begin h[k] = rnd16(); hn[k] = rnd16(); end
        load_coeffs(h);
        x = rnd16(); want = m_push(x);
        bus.i_data = DW'(x); bus.i_data_valid = 1'b1;
        tick();
        bus.i_data_valid = 1'b0;
        for (int k = 0; k < NT; k++) begin
            bus.i_coeff_we = 1'b1; bus.i_coeff_addr = AW'(k); bus.i_coeff_data = CW'(hn[k]);
            bus.i_coeff_commit = (k == 1);
            m_shadow[k] = sxc(hn[k]);
            tick();
            if (k == 1) begin
                n_tests++;
                if (bus.o_commit_pending !== 1'b1) begin n_fail++; $display("FAIL cb_pending_set: got %b want 1", bus.o_commit_pending); end
            end
        end
        bus.i_coeff_we = 1'b0; bus.i_coeff_commit = 1'b0;
        m_commit(1'b0);
        n_tests++;
        if (bus.o_data_valid !== 1'b1 || bus.o_data_sum !== want) begin
            n_fail++; $display("FAIL cb_old_coeffs: valid=%b sum=%h want 1 %h", bus.o_data_valid, bus.o_data_sum, want);
        end
        tick();
        n_tests++;
        if (bus.o_commit_pending !== 1'b1) begin n_fail++; $display("FAIL cb_pending_hold: got %b want 1", bus.o_commit_pending); end
        tick();
        n_tests++;
        if (bus.o_commit_pending !== 1'b0) begin n_fail++; $display("FAIL cb_pending_clear: got %b want 0", bus.o_commit_pending); end
        x = rnd16(); want = m_push(x);
        run_sample(x, got, lat, bok);
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL cb_new_coeffs: got %h want %h", got, want); end
    endtask

    task automatic test_reset_mid_mac();
        int h[NT]; logic [OW-1:0] got, want; int lat, x; bit bok;
        do_reset();
        for (int k = 0; k < NT; k++) h[k] = rnd16();
        load_coeffs(h);
        for (int i = 0; i < NT; i++) begin x = rnd16(); void'(m_push(x)); run_sample(x, got, lat, bok); end
        bus.i_data = DW'(rnd16()); bus.i_data_valid = 1'b1;
        tick();
        bus.i_data_valid = 1'b0; bus.i_coeff_commit = 1'b1;
        tick();
        bus.i_coeff_commit = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        n_tests++;
        if ({bus.o_busy, bus.o_data_valid, bus.o_commit_pending, bus.o_data_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL rm_abort: busy/valid/pending/ready got %b%b%b%b want 0000", bus.o_busy, bus.o_data_valid, bus.o_commit_pending, bus.o_data_ready);
        end
        reset_n = 1'b1; m_reset(); #1;
        void'(m_push(32'h4000));
        run_sample(32'h4000, got, lat, bok);
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL rm_zero_active: got %h want 0", got); end
        bus.i_coeff_commit = 1'b1; tick(); bus.i_coeff_commit = 1'b0; m_commit(1'b1);
        void'(m_push(32'h4000));
        run_sample(32'h4000, got, lat, bok);
        n_tests++;
        if (got !== '0) begin n_fail++; $display("FAIL rm_zero_shadow: got %h want 0", got); end
        for (int k = 0; k < NT; k++) h[k] = 32'h4000;
        load_coeffs(h);
        want = m_push(0);
        run_sample(0, got, lat, bok);
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL rm_history_clear: got %h want %h", got, want); end
    endtask

    task automatic test_back_to_back();
        int h[NT]; int xs[4]; logic [OW-1:0] got, want; int cnt; bit seen;
        do_reset();
        for (int k = 0; k < NT; k++) h[k] = rnd16();
        load_coeffs(h);
        for (int i = 0; i < 4; i++) xs[i] = rnd16();
        bus.i_data = DW'(xs[0]); bus.i_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            want = m_push(xs[i]);
            bus.i_data = DW'(xs[i+1]);
            cnt = 0; seen = 1'b0; got = '0;
            while (!bus.o_data_ready && cnt < 50) begin
                if (bus.o_data_valid && !seen) begin got = bus.o_data_sum; seen = 1'b1; end
                tick(); cnt++;
            end
            if (i == 2) bus.i_data_valid = 1'b0;
            n_tests++;
            if (!seen || got !== want) begin n_fail++; $display("FAIL b2b_sum[%0d]: seen=%b got %h want %h", i, seen, got, want); end
            n_tests++;
            if (cnt + 1 != NT + 2) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, cnt + 1, NT + 2); end
        end
    endtask

    task automatic test_random();
        int h[NT]; logic [OW-1:0] got, want; int lat, x; bit bok;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NT; k++) h[k] = rnd16();
            load_coeffs(h);
            for (int i = 0; i < 6; i++) begin
                x = rnd16(); want = m_push(x);
                run_sample(x, got, lat, bok);
                n_tests++;
                if (got !== want) begin n_fail++; $display("FAIL rand_sum[%0d.%0d]: got %h want %h", r, i, got, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_negative();
        test_backpressure();
        test_commit_busy();
        test_reset_mid_mac();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
